// File: rtl/rsa_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation engine.
package rsa_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, PRE, ISSUE, WAIT} state_t;

    localparam logic [1:0] SEL_C = 2'd0;
    localparam logic [1:0] SEL_M = 2'd1;
    localparam logic [1:0] SEL_E = 2'd2;
    localparam logic [1:0] SEL_N = 2'd3;

    // A single-word key still gets a 1-bit address so the port never collapses to zero width.
    function automatic int unsigned addr_w(int unsigned key_w, int unsigned data_w);
        return (key_w / data_w > 1) ? $clog2(key_w / data_w) : 1;
    endfunction

    function automatic int unsigned modexp_latency(int unsigned key_w);
        return 1 + key_w + key_w * (key_w + 3) + 1;
    endfunction

endpackage

// File: rtl/rsa_modexp_core_if.sv
// Host bus for the modexp core: word-wide register access plus control/status.
interface rsa_modexp_core_if
    import rsa_pkg::*;
#(
    parameter int unsigned KEY_W  = 256,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = addr_w(KEY_W, DATA_W)
);
    logic              we;
    logic              oe;
    logic              start;
    logic              abort;
    logic [1:0]        reg_sel;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              ready;
    logic              done;
    logic              err;

    modport master (output we, oe, start, abort, reg_sel, addr, data_i,
                    input  data_o, ready, done, err);
    modport slave  (input  we, oe, start, abort, reg_sel, addr, data_i,
                    output data_o, ready, done, err);
endinterface

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: out = a*b*2^-W mod n, W+2 cycles after start.
module mont_mul #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] out,
    output logic         done
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  a_r, b_r, n_r, sub;
    logic [W+1:0]  acc, acc_add, acc_n;
    logic [CW-1:0] cnt;
    logic          busy;

    always_comb begin
        acc_add = acc + (a_r[0] ? {2'b00, b_r} : '0);
        acc_n   = acc_add[0] ? acc_add + {2'b00, n_r} : acc_add;
        // Final value is < 2n, so the reduced result fits in W bits.
        sub     = acc[W-1:0] - n_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            n_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            out  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                n_r  <= n;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt == CW'(W)) begin
                    out  <= (acc >= {2'b00, n_r}) ? sub : acc[W-1:0];
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    acc <= acc_n >> 1;
                    a_r <= a_r >> 1;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rsa_modexp_core.sv
// C = M^E mod N engine: operand register file, Montgomery pre-scaling and LSB-first square-and-multiply.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int unsigned KEY_W  = 256,
    parameter int unsigned DATA_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    rsa_modexp_core_if.slave bus
);
    localparam int unsigned CW = $clog2(KEY_W) + 1;

    state_t            state, state_nx;
    logic [KEY_W-1:0]  m_r, e_r, n_r, c_r, s_r, t_r, s_mm, t_mm, t_red;
    logic [KEY_W:0]    t_dbl;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rd_word, data_o_r;
    logic              ready, mm_start, mm_clr, s_done, t_done;
    logic              operand_bad, last, e_bit, bus_wr, bus_rd, go, done_r, err_r;

    assign bus_wr      = bus.we & ready;
    assign bus_rd      = bus.oe & ready;
    assign go          = bus.start & ~bus.we & ready;
    assign operand_bad = ~n_r[0] | (n_r == KEY_W'(1)) | (m_r >= n_r);
    assign last        = (cnt == CW'(KEY_W - 1));
    assign e_bit       = e_r[cnt[CW-2:0]];
    assign t_dbl       = {t_r, 1'b0};
    assign t_red       = (t_dbl >= {1'b0, n_r}) ? (t_dbl[KEY_W-1:0] - n_r) : t_dbl[KEY_W-1:0];

    assign bus.ready  = ready;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.data_o = data_o_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.abort && state != IDLE) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (go) state_nx = CHECK;
                CHECK:   state_nx = operand_bad ? IDLE : PRE;
                PRE:     if (last) state_nx = ISSUE;
                ISSUE:   state_nx = WAIT;
                WAIT:    if (s_done && t_done) state_nx = last ? IDLE : ISSUE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        ready    = (state == IDLE);
        mm_start = (state == ISSUE);
        mm_clr   = bus.abort && (state != IDLE);
    end

    always_comb begin
        rd_word = '0;
        case (bus.reg_sel)
            SEL_C:   rd_word = c_r[bus.addr*DATA_W +: DATA_W];
            SEL_M:   rd_word = m_r[bus.addr*DATA_W +: DATA_W];
            SEL_E:   rd_word = e_r[bus.addr*DATA_W +: DATA_W];
            default: rd_word = n_r[bus.addr*DATA_W +: DATA_W];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r      <= '0;
            e_r      <= '0;
            n_r      <= '0;
            c_r      <= '0;
            s_r      <= '0;
            t_r      <= '0;
            cnt      <= '0;
            data_o_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus_rd) data_o_r <= rd_word;
            if (bus_wr) begin
                case (bus.reg_sel)
                    SEL_M:   m_r[bus.addr*DATA_W +: DATA_W] <= bus.data_i;
                    SEL_E:   e_r[bus.addr*DATA_W +: DATA_W] <= bus.data_i;
                    SEL_N:   n_r[bus.addr*DATA_W +: DATA_W] <= bus.data_i;
                    default: ;
                endcase
            end
            if (!mm_clr) begin
                case (state)
                    CHECK: begin
                        err_r <= operand_bad;
                        t_r   <= m_r;
                        s_r   <= KEY_W'(1);
                        cnt   <= '0;
                    end
                    PRE: begin
                        t_r <= t_red;
                        cnt <= last ? '0 : cnt + 1'b1;
                    end
                    // S stays plain, T carries the Montgomery factor, so C needs no post-conversion.
                    WAIT: if (s_done && t_done) begin
                        if (e_bit) s_r <= s_mm;
                        t_r <= t_mm;
                        if (last) begin
                            c_r    <= e_bit ? s_mm : s_r;
                            done_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    mont_mul #(.W(KEY_W)) u_mm_s (
        .clk(clk), .reset(reset), .clr(mm_clr), .start(mm_start),
        .a(s_r), .b(t_r), .n(n_r), .out(s_mm), .done(s_done)
    );

    mont_mul #(.W(KEY_W)) u_mm_t (
        .clk(clk), .reset(reset), .clr(mm_clr), .start(mm_start),
        .a(t_r), .b(t_r), .n(n_r), .out(t_mm), .done(t_done)
    );
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: an 8-bit and a 16-bit instance sharing one host driver.
module tb_rsa_modexp_core;
    import rsa_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0, oe = 1'b0, start = 1'b0, abort = 1'b0, sel16 = 1'b0;
    logic [1:0] reg_sel = '0;
    logic       addr = 1'b0;
    logic [7:0] data_i = '0;
    logic [7:0] dout;
    logic       rdy, dn, er;
    int         n_checks = 0, n_fail = 0, done8 = 0, done16 = 0;

    rsa_modexp_core_if #(.KEY_W(8),  .DATA_W(8)) bus8 ();
    rsa_modexp_core_if #(.KEY_W(16), .DATA_W(8)) bus16 ();

    assign bus8.we      = we & ~sel16;
    assign bus8.oe      = oe & ~sel16;
    assign bus8.start   = start & ~sel16;
    assign bus8.abort   = abort & ~sel16;
    assign bus8.reg_sel = reg_sel;
    assign bus8.addr    = addr;
    assign bus8.data_i  = data_i;
    assign bus16.we      = we & sel16;
    assign bus16.oe      = oe & sel16;
    assign bus16.start   = start & sel16;
    assign bus16.abort   = abort & sel16;
    assign bus16.reg_sel = reg_sel;
    assign bus16.addr    = addr;
    assign bus16.data_i  = data_i;

    assign dout = sel16 ? bus16.data_o : bus8.data_o;
    assign rdy  = sel16 ? bus16.ready  : bus8.ready;
    assign dn   = sel16 ? bus16.done   : bus8.done;
    assign er   = sel16 ? bus16.err    : bus8.err;

    rsa_modexp_core #(.KEY_W(8), .DATA_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave)
    );
    rsa_modexp_core #(.KEY_W(16), .DATA_W(8)) u_dut16 (
        .clk(clk), .reset(reset), .bus(bus16.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus8.done)  done8++;
        if (bus16.done) done16++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] rs, input logic a, input logic [7:0] d);
        reg_sel = rs; addr = a; data_i = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] rs, input logic a, output logic [7:0] d);
        reg_sel = rs; addr = a; oe = 1'b1;
        tick();
        oe = 1'b0;
        d = dout;
    endtask

    task automatic run_op(output int cyc, output logic saw_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!rdy && cyc < 3000) begin
            tick();
            cyc++;
        end
        saw_done = dn;
        check_eq("op_finish", {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cyc, base;
        logic       sd;
        logic [7:0] d;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values on both instances
        for (int s = 0; s < 2; s++) begin
            sel16 = (s == 1);
            #1;
            check_eq("rst_ready", {31'd0, rdy}, 32'd1);
            check_eq("rst_done",  {31'd0, dn},  32'd0);
            check_eq("rst_err",   {31'd0, er},  32'd0);
            check_eq("rst_data_o", {24'd0, dout}, 32'h00);
        end

        // KEY_W=8: 5^3 mod 7 = 6
        sel16 = 1'b0;
        wr(SEL_M, 1'b0, 8'd5); wr(SEL_E, 1'b0, 8'd3); wr(SEL_N, 1'b0, 8'd7);
        base = done8;
        run_op(cyc, sd);
        check_eq("lat8", cyc, 32'd98);
        check_eq("done8_pulse", {31'd0, sd}, 32'd1);
        check_eq("err8_clear", {31'd0, er}, 32'd0);
        rd(SEL_C, 1'b0, d);
        check_eq("c8_5_3_7", {24'd0, d}, 32'h06);
        check_eq("done8_count", done8 - base, 32'd1);

        // KEY_W=16: 4^13 mod 497 = 445
        sel16 = 1'b1;
        wr(SEL_M, 1'b0, 8'h04); wr(SEL_M, 1'b1, 8'h00);
        wr(SEL_E, 1'b0, 8'h0D); wr(SEL_E, 1'b1, 8'h00);
        wr(SEL_N, 1'b0, 8'hF1); wr(SEL_N, 1'b1, 8'h01);
        run_op(cyc, sd);
        check_eq("lat16", cyc, modexp_latency(16));
        check_eq("done16_pulse", {31'd0, sd}, 32'd1);
        rd(SEL_C, 1'b0, d); check_eq("c16_lo", {24'd0, d}, 32'hBD);
        rd(SEL_C, 1'b1, d); check_eq("c16_hi", {24'd0, d}, 32'h01);
        run_op(cyc, sd);
        rd(SEL_C, 1'b0, d); check_eq("c16_lo_again", {24'd0, d}, 32'hBD);

        // E=0 gives 1; invalid operands raise err without touching C
        sel16 = 1'b0;
        wr(SEL_E, 1'b0, 8'd0);
        run_op(cyc, sd);
        rd(SEL_C, 1'b0, d); check_eq("c8_e0", {24'd0, d}, 32'h01);
        wr(SEL_N, 1'b0, 8'd8);
        base = done8;
        run_op(cyc, sd);
        check_eq("err_even_lat", cyc, 32'd2);
        check_eq("err_even_flag", {31'd0, er}, 32'd1);
        check_eq("err_even_nodone", {31'd0, sd}, 32'd0);
        tick();
        check_eq("err_even_donecnt", done8 - base, 32'd0);
        rd(SEL_C, 1'b0, d); check_eq("err_even_c", {24'd0, d}, 32'h01);
        wr(SEL_N, 1'b0, 8'd7); wr(SEL_M, 1'b0, 8'd9);
        run_op(cyc, sd);
        check_eq("err_m_ge_n", {31'd0, er}, 32'd1);

        // Abort at cycle 40, then restart
        wr(SEL_M, 1'b0, 8'd5); wr(SEL_E, 1'b0, 8'd3);
        base = done8;
        start = 1'b1; tick(); start = 1'b0;
        repeat (39) tick();
        check_eq("abort_busy", {31'd0, rdy}, 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_ready", {31'd0, rdy}, 32'd1);
        check_eq("abort_err", {31'd0, er}, 32'd0);
        tick();
        check_eq("abort_nodone", done8 - base, 32'd0);
        rd(SEL_C, 1'b0, d); check_eq("abort_c_hold", {24'd0, d}, 32'h01);
        run_op(cyc, sd);
        rd(SEL_C, 1'b0, d); check_eq("abort_restart_c", {24'd0, d}, 32'h06);

        // Bus accesses while busy are ignored
        sel16 = 1'b1;
        rd(SEL_C, 1'b1, d);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        wr(SEL_N, 1'b0, 8'hFF);
        reg_sel = SEL_N; addr = 1'b0; oe = 1'b1; tick(); oe = 1'b0;
        check_eq("busy_oe_hold", {24'd0, dout}, 32'h01);
        cyc = 0;
        while (!rdy && cyc < 3000) begin tick(); cyc++; end
        check_eq("busy_finish", {31'd0, rdy}, 32'd1);
        rd(SEL_N, 1'b0, d); check_eq("busy_we_ignored", {24'd0, d}, 32'hF1);
        rd(SEL_C, 1'b0, d); check_eq("busy_c", {24'd0, d}, 32'hBD);

        // we+oe together: read returns the pre-write word
        reg_sel = SEL_M; addr = 1'b0; data_i = 8'h06; we = 1'b1; oe = 1'b1;
        tick();
        we = 1'b0; oe = 1'b0;
        check_eq("we_oe_old", {24'd0, dout}, 32'h04);
        rd(SEL_M, 1'b0, d); check_eq("we_oe_new", {24'd0, d}, 32'h06);

        // we+start together: write lands, nothing starts
        base = done16;
        reg_sel = SEL_E; addr = 1'b0; data_i = 8'h05; we = 1'b1; start = 1'b1;
        tick();
        we = 1'b0; start = 1'b0;
        check_eq("we_start_ready", {31'd0, rdy}, 32'd1);
        tick();
        check_eq("we_start_nodone", done16 - base, 32'd0);
        rd(SEL_E, 1'b0, d); check_eq("we_start_write", {24'd0, d}, 32'h05);

        // Reset while the multipliers are running
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        check_eq("rst_mid_busy", {31'd0, rdy}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_ready", {31'd0, rdy}, 32'd1);
        check_eq("rst_mid_done",  {31'd0, dn},  32'd0);
        check_eq("rst_mid_err",   {31'd0, er},  32'd0);
        check_eq("rst_mid_data_o", {24'd0, dout}, 32'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        rd(SEL_M, 1'b0, d); check_eq("rst_mid_m", {24'd0, d}, 32'h00);
        rd(SEL_N, 1'b1, d); check_eq("rst_mid_n", {24'd0, d}, 32'h00);
        rd(SEL_C, 1'b0, d); check_eq("rst_mid_c", {24'd0, d}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
